// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO interconnect.
// FSM state encoding, default region map and error counter width.
package mmio_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  // Default region indices (top address bits)
  localparam int unsigned SEL_MEM     = 0;
  localparam int unsigned SEL_LCD     = 1;
  localparam int unsigned SEL_VRAM    = 2;
  localparam int unsigned SEL_PALETTE = 3;

  localparam int unsigned ERR_COUNT_W = 8;

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational region decoder: top SEL_BITS of the address give the slave index;
// hit is low when the index has no slave behind it.
module mmio_addr_decode #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned SEL_BITS   = 2,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic [ADDR_W-1:0]   addr_i,
  output logic [SEL_BITS-1:0] idx_o,
  output logic                hit_o
);

  logic unused_addr_low;

  assign idx_o = addr_i[ADDR_W-1 -: SEL_BITS];
  assign hit_o = 32'(idx_o) < NUM_SLAVES;

  // Offset bits are not part of region selection
  assign unused_addr_low = ^addr_i[ADDR_W-SEL_BITS-1:0];

endmodule

// File: rtl/mmio_interconnect.sv
// CPU-to-peripheral MMIO interconnect: region decode, one outstanding request,
// valid/ready toward the slave. Optional slave timeout via MMIO_TIMEOUT_EN.
module mmio_interconnect
  import mmio_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned SEL_BITS   = 2,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  input  logic [DATA_W/8-1:0]          req_wstrb,
  output logic                         resp_valid,
  output logic [DATA_W-1:0]            resp_rdata,
  output logic                         resp_err,
  output logic [NUM_SLAVES-1:0]        s_valid,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [DATA_W/8-1:0]          s_wstrb,
  input  logic [NUM_SLAVES-1:0]        s_ready,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  output logic [ERR_COUNT_W-1:0]       err_count
);

  localparam int unsigned StrbW = DATA_W / 8;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [StrbW-1:0]       wstrb_q, wstrb_d;
  logic [SEL_BITS-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [ERR_COUNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [SEL_BITS-1:0]    dec_idx;
  logic                   dec_hit;
  logic                   sel_ready;
  logic [DATA_W-1:0]      sel_rdata;
  logic                   timeout;

  mmio_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_BITS   (SEL_BITS),
    .ADDR_W     (ADDR_W)
  ) u_decode (
    .addr_i (req_addr),
    .idx_o  (dec_idx),
    .hit_o  (dec_hit)
  );

  // Route the latched slave's ready/rdata; other slaves' signals are ignored
  always_comb begin
    s_valid   = '0;
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == SEL_BITS'(i)) begin
        s_valid[i] = (state_q == StWait);
        sel_ready  = s_ready[i];
        sel_rdata  = s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef MMIO_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == StIdle) begin
      wait_cnt_d = '0;
    end else if (state_q == StWait) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Counter holds the number of WAIT cycles already elapsed before this one
  assign timeout = (state_q == StWait) && (wait_cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  logic unused_timeout;

  assign timeout        = 1'b0;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    idx_d     = idx_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          idx_d   = dec_idx;
          if (dec_hit) begin
            state_d = StWait;
          end else begin
            state_d = StResp;
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end
      end
      StWait: begin
        // A ready in the timeout cycle still completes normally
        if (sel_ready) begin
          state_d = StResp;
          rdata_d = (wstrb_q != '0) ? '0 : sel_rdata;
          err_d   = 1'b0;
        end else if (timeout) begin
          state_d = StResp;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
        rdata_d = '0;
        err_d   = 1'b0;
        if (err_q && (err_cnt_q != '1)) begin
          err_cnt_d = err_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      idx_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      idx_q     <= idx_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign s_addr     = addr_q;
  assign s_wdata    = wdata_q;
  assign s_wstrb    = wstrb_q;
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_mmio_interconnect.sv
// Self-checking bench for mmio_interconnect with three slaves (region 3 unmapped).
// Timeout expectations follow MMIO_TIMEOUT_EN when it is defined.
module tb_mmio_interconnect;

  localparam int NS    = 3;
  localparam int TO    = 64;
  localparam int BOUND = 200;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [31:0]     req_addr = '0;
  logic [31:0]     req_wdata = '0;
  logic [3:0]      req_wstrb = '0;
  logic            resp_valid;
  logic [31:0]     resp_rdata;
  logic            resp_err;
  logic [NS-1:0]   s_valid;
  logic [31:0]     s_addr;
  logic [31:0]     s_wdata;
  logic [3:0]      s_wstrb;
  logic [NS-1:0]   s_ready = '0;
  logic [NS*32-1:0] s_rdata;
  logic [7:0]      err_count;

  logic [31:0] slave_mem [NS];
  int checks = 0;
  int failures = 0;
  int model_errs = 0;

  assign s_rdata = {slave_mem[2], slave_mem[1], slave_mem[0]};

  always #5 clk = ~clk;

  mmio_interconnect #(
    .NUM_SLAVES (NS),
    .SEL_BITS   (2),
    .ADDR_W     (32),
    .DATA_W     (32),
    .TIMEOUT    (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .s_valid    (s_valid),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_ready    (s_ready),
    .s_rdata    (s_rdata),
    .err_count  (err_count)
  );

  // Reference: latency counted in cycles from accept edge to resp_valid cycle;
  // delay = WAIT cycle (1-based) in which the slave first raises ready.
  function automatic void model(input logic [31:0] addr, input logic [3:0] wstrb,
                                input int delay, input logic [31:0] sdata,
                                output int lat, output logic err, output logic [31:0] rdata);
    int idx;
    idx = int'(addr[31:30]);
    if (idx >= NS) begin
      lat = 1; err = 1'b1; rdata = '0;
    end
`ifdef MMIO_TIMEOUT_EN
    else if (delay > TO) begin
      lat = TO + 1; err = 1'b1; rdata = '0;
    end
`endif
    else begin
      lat = delay + 1; err = 1'b0; rdata = (wstrb != 0) ? 32'h0 : sdata;
    end
  endfunction

  // Drives one transaction; bad counts cycles whose side-band outputs were wrong
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int delay,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output int bad, output logic [7:0] ecnt);
    int idx;
    logic [NS-1:0] onehot;
    bit done;
    idx = int'(addr[31:30]);
    onehot = (idx < NS) ? NS'(1 << idx) : '0;
    lat = -1; rdata = 'x; err = 1'bx; bad = 0; done = 0;
    req_valid = 1'b1; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom);
    for (int c = 1; c <= BOUND && !done; c++) begin
      s_ready = NS'($urandom) & ~onehot;
      if (c >= delay) s_ready = s_ready | onehot;
      @(negedge clk);
      if (resp_valid) begin
        lat = c; rdata = resp_rdata; err = resp_err; done = 1;
        if (s_valid !== '0 || req_ready !== 1'b0) bad++;
      end else if (s_valid !== onehot || s_addr !== addr || s_wdata !== wdata ||
                   s_wstrb !== wstrb || req_ready !== 1'b0) begin
        bad++;
      end
      @(posedge clk); #1;
    end
    s_ready = '0;
    @(negedge clk);
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) bad++;
    ecnt = err_count;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin failures++; $display("FAIL rst_resp got=%h/%b exp=0/0", resp_rdata, resp_err); end
    checks++; if (s_valid !== '0) begin failures++; $display("FAIL rst_s_valid got=%b exp=0", s_valid); end
    checks++; if (s_addr !== 32'h0 || s_wdata !== 32'h0 || s_wstrb !== 4'h0) begin failures++; $display("FAIL rst_s_bus got=%h/%h/%h exp=0", s_addr, s_wdata, s_wstrb); end
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL rst_err_count got=%0d exp=0", err_count); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL rst_release got=%b/%b exp=1/0", req_ready, resp_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_read_basic();
    int lat, bad, elat; logic [31:0] rd, erd; logic er, eer; logic [7:0] ec;
    for (int i = 0; i < NS; i++) slave_mem[i] = $urandom;
    slave_mem[1] = 32'hDEAD_BEEF;
    model(32'h4000_0010, 4'b0000, 1, slave_mem[1], elat, eer, erd);
    run_txn(32'h4000_0010, $urandom, 4'b0000, 1, lat, rd, er, bad, ec);
    if (eer) model_errs = (model_errs < 255) ? model_errs + 1 : 255;
    checks++; if (lat !== elat) begin failures++; $display("FAIL read_lat got=%0d exp=%0d", lat, elat); end
    checks++; if (rd !== erd) begin failures++; $display("FAIL read_rdata got=%h exp=%h", rd, erd); end
    checks++; if (er !== eer) begin failures++; $display("FAIL read_err got=%b exp=%b", er, eer); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL read_sideband got=%0d exp=0", bad); end
  endtask

  task automatic test_write_wait();
    int lat, bad, elat; logic [31:0] rd, erd; logic er, eer; logic [7:0] ec;
    for (int i = 0; i < NS; i++) slave_mem[i] = $urandom;
    model(32'h0000_0020, 4'b0011, 5, slave_mem[0], elat, eer, erd);
    run_txn(32'h0000_0020, 32'h1234_5678, 4'b0011, 5, lat, rd, er, bad, ec);
    if (eer) model_errs = (model_errs < 255) ? model_errs + 1 : 255;
    checks++; if (lat !== elat) begin failures++; $display("FAIL write_lat got=%0d exp=%0d", lat, elat); end
    checks++; if (rd !== erd) begin failures++; $display("FAIL write_rdata got=%h exp=%h", rd, erd); end
    checks++; if (er !== eer) begin failures++; $display("FAIL write_err got=%b exp=%b", er, eer); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL write_sideband got=%0d exp=0", bad); end
  endtask

  task automatic test_unmapped();
    int lat, bad, elat; logic [31:0] rd, erd; logic er, eer; logic [7:0] ec;
    model(32'hC000_0000, 4'b0000, 1, 32'h0, elat, eer, erd);
    run_txn(32'hC000_0000, $urandom, 4'b0000, 1, lat, rd, er, bad, ec);
    if (eer) model_errs = (model_errs < 255) ? model_errs + 1 : 255;
    checks++; if (lat !== elat) begin failures++; $display("FAIL unmap_lat got=%0d exp=%0d", lat, elat); end
    checks++; if (rd !== erd || er !== eer) begin failures++; $display("FAIL unmap_resp got=%h/%b exp=%h/%b", rd, er, erd, eer); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL unmap_sideband got=%0d exp=0", bad); end
    checks++; if (int'(ec) !== model_errs) begin failures++; $display("FAIL unmap_err_count got=%0d exp=%0d", ec, model_errs); end
  endtask

  task automatic test_long_wait();
    int delays [4] = '{TO - 1, TO, TO + 1, TO + 30};
    int lat, bad, elat; logic [31:0] rd, erd, a; logic er, eer; logic [7:0] ec;
    foreach (delays[k]) begin
      for (int i = 0; i < NS; i++) slave_mem[i] = $urandom;
      a = {2'b10, 30'($urandom)};
      model(a, 4'b0000, delays[k], slave_mem[2], elat, eer, erd);
      run_txn(a, $urandom, 4'b0000, delays[k], lat, rd, er, bad, ec);
      if (eer) model_errs = (model_errs < 255) ? model_errs + 1 : 255;
      checks++; if (lat !== elat || rd !== erd || er !== eer) begin
        failures++; $display("FAIL long_wait d=%0d got lat=%0d rd=%h err=%b exp lat=%0d rd=%h err=%b", delays[k], lat, rd, er, elat, erd, eer);
      end
      checks++; if (bad !== 0 || int'(ec) !== model_errs) begin
        failures++; $display("FAIL long_wait_side d=%0d got bad=%0d cnt=%0d exp 0/%0d", delays[k], bad, ec, model_errs);
      end
    end
  endtask

  task automatic test_random();
    int lat, bad, elat, d; logic [31:0] rd, erd, a; logic [3:0] ws; logic er, eer; logic [7:0] ec;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NS; i++) slave_mem[i] = $urandom;
      a = $urandom;
      ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      d = $urandom_range(1, 8);
      model(a, ws, d, (int'(a[31:30]) < NS) ? slave_mem[a[31:30]] : 32'h0, elat, eer, erd);
      run_txn(a, $urandom, ws, d, lat, rd, er, bad, ec);
      if (eer) model_errs = (model_errs < 255) ? model_errs + 1 : 255;
      checks++; if (lat !== elat || rd !== erd || er !== eer) begin
        failures++; $display("FAIL random n=%0d a=%h got lat=%0d rd=%h err=%b exp lat=%0d rd=%h err=%b", n, a, lat, rd, er, elat, erd, eer);
      end
      checks++; if (bad !== 0 || int'(ec) !== model_errs) begin
        failures++; $display("FAIL random_side n=%0d got bad=%0d cnt=%0d exp 0/%0d", n, bad, ec, model_errs);
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    slave_mem[2] = $urandom;
    req_valid = 1'b1; req_addr = 32'h8000_0004; req_wstrb = 4'h0;
    @(posedge clk); #1;
    req_valid = 1'b0; s_ready = '0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if (s_valid !== '0 || resp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_drop got s_valid=%b resp_valid=%b exp 0/0", s_valid, resp_valid); end
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL rstmid_err_count got=%0d exp=0", err_count); end
    model_errs = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    s_ready = '1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || s_valid !== '0 || req_ready !== 1'b1) bad++;
    end
    s_ready = '0;
    checks++; if (bad !== 0) begin failures++; $display("FAIL rstmid_quiet got=%0d bad cycles exp=0", bad); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturate();
    int lat, bad, badsum = 0; logic [31:0] rd; logic er; logic [7:0] ec;
    for (int n = 0; n < 300; n++) begin
      run_txn({2'b11, 30'($urandom)}, $urandom, 4'($urandom), 1, lat, rd, er, bad, ec);
      model_errs = (model_errs < 255) ? model_errs + 1 : 255;
      if (bad != 0 || lat != 1 || er !== 1'b1 || int'(ec) != model_errs) badsum++;
    end
    checks++; if (badsum !== 0) begin failures++; $display("FAIL saturate_txns got=%0d bad exp=0", badsum); end
    checks++; if (int'(err_count) !== model_errs) begin failures++; $display("FAIL saturate_count got=%0d exp=%0d", err_count, model_errs); end
  endtask

  initial begin
    for (int i = 0; i < NS; i++) slave_mem[i] = '0;
    test_reset();
    test_read_basic();
    test_write_wait();
    test_unmapped();
    test_long_wait();
    test_random();
    test_reset_mid();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mmio_interconnect.md
# mmio_interconnect

Parametrised memory-mapped interconnect between the pipelined CPU data port and NUM_SLAVES peripherals: RAM, LCD, VRAM, palette and future devices. It decodes the top address bits into a slave index and registers each request. It runs a valid/ready handshake toward the selected slave, so slow peripherals can stall the CPU. It returns read data with an error flag, raised for unmapped regions and, when compiled in, for slave timeouts.

## Interface
- NUM_SLAVES, 4: number of slave channels, 1..16.
- SEL_BITS, 2: upper address bits used for region select; require 2**SEL_BITS >= NUM_SLAVES.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; strobe width is DATA_W/8.
- TIMEOUT, 64: maximum wait cycles per slave access (MMIO_TIMEOUT_EN only).

Ports:
- clk  in  1  system clock; one clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  interconnect can accept a request.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_wstrb  in  DATA_W/8  byte write enables; all-zero means read.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  DATA_W  read data; 0 for writes and errors.
- resp_err  out  1  response is an error, qualified by resp_valid.
- s_valid  out  NUM_SLAVES  one-hot request to a slave.
- s_addr  out  ADDR_W  latched address, shared by all slaves.
- s_wdata  out  DATA_W  latched write data, shared by all slaves.
- s_wstrb  out  DATA_W/8  latched strobes, shared by all slaves.
- s_ready  in  NUM_SLAVES  slave completes the access.
- s_rdata  in  NUM_SLAVES*DATA_W  flattened slave read data; slave i occupies bits [i*DATA_W +: DATA_W].
- err_count  out  8  saturating count of error responses.

## Operation
- Slave index is req_addr[ADDR_W-1 -: SEL_BITS]. An index >= NUM_SLAVES is unmapped.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr, wdata, wstrb and index.
  - Mapped: go to WAIT.
  - Unmapped: go to RESP with err=1.
- WAIT:
  - s_valid[index]=1; all other s_valid bits are 0.
  - On s_ready[index], capture s_rdata slice (forced to 0 if wstrb != 0) and go to RESP with err=0.
  - s_ready bits of non-selected slaves are ignored.
- RESP:
  - resp_valid=1 for exactly one cycle; rdata and err are registered.
  - Return to IDLE.
  - err_count increments on every error response and saturates at 255.
- One transaction is outstanding at a time. req_ready=0 in WAIT and RESP.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, s_valid=0, s_addr/s_wdata/s_wstrb=0, err_count=0, wait counter 0.
- Accept at edge N: s_valid is high from N+1.
- s_ready sampled at edge M: resp_valid is high in cycle M+1.
- Minimum latency is 2 cycles from accept to resp_valid (slave ready in the first WAIT cycle).
- Unmapped access: resp_valid with err=1 in cycle N+1.
- A slave may hold s_ready high constantly; only the first WAIT cycle matters.
- Reset asserted mid-transaction: s_valid and resp_valid drop immediately, the transaction is discarded and no response is issued.
- s_addr/s_wdata/s_wstrb are stable for the entire WAIT period.

## Configuration
- MMIO_TIMEOUT_EN defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle.
  - If TIMEOUT cycles elapse without s_ready, go to RESP with err=1 and rdata=0; s_valid drops.
  - If s_ready and the timeout occur in the same cycle, s_ready wins (normal response).
- MMIO_TIMEOUT_EN undefined: no counter; WAIT persists until s_ready. Errors come only from unmapped regions.

## Structure
- Package mmio_pkg:
  - FSM state typedef (IDLE/WAIT/RESP).
  - Default region indices: SEL_MEM=0, SEL_LCD=1, SEL_VRAM=2, SEL_PALETTE=3.
  - ERR_COUNT_W=8.
- Sub-module mmio_addr_decode: combinational address to {index, hit}, parametrised by NUM_SLAVES, SEL_BITS and ADDR_W.

## Test plan
- Read slave 1, addr 0x4000_0010, s_ready asserted in the first WAIT cycle, rdata 0xDEAD_BEEF -> resp_valid 2 cycles after accept, rdata 0xDEADBEEF, err=0, only s_valid[1] high.
- Write slave 0, wstrb 4'b0011, wdata 0x1234_5678, s_ready after 5 cycles -> s_wstrb 0011 held for all 5 cycles, resp_rdata=0, err=0, req_ready low throughout.
- NUM_SLAVES=3, addr 0xC000_0000 -> no s_valid pulse, resp err=1 next cycle, err_count=1.
- MMIO_TIMEOUT_EN, TIMEOUT=64, slave never ready -> resp err=1 exactly 64 WAIT cycles after entry; s_ready on cycle 64 instead -> err=0.
- rst raised during WAIT -> s_valid=0 immediately, no resp_valid, req_ready=1 after release.
- 300 unmapped accesses -> err_count saturates at 255.
